// File: rtl/sdram_wr_recovery_guard_pkg.sv
// SDRAM command encodings and defaults shared by the
// command-issue stage and the bus-side checkers.
package sdram_cmd_pkg;

    typedef enum logic [1:0] {
        NOP = 2'b00,
        PRE = 2'b01,
        WR  = 2'b10,
        RD  = 2'b11
    } cmd_t;

    localparam int TWR_DEFAULT = 4;
    localparam int TWR_MIN     = 1;
    localparam int TWR_MAX     = 7;

endpackage

// File: rtl/sdram_wr_recovery_guard_if.sv
// Request-side valid/ready handshake into the
// write-recovery guard.
interface sdram_wr_recovery_guard_if
    import sdram_cmd_pkg::*;
#(
    parameter int BA_WIDTH = 3
);

    logic                req_valid;
    cmd_t                req_cmd;
    logic [BA_WIDTH-1:0] req_bank;
    logic                req_ready;

    modport master (
        output req_valid,
        output req_cmd,
        output req_bank,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_cmd,
        input  req_bank,
        output req_ready
    );

endinterface

// File: rtl/sdram_wr_recovery_guard_bank_wr_timer.sv
// Per-bank write recovery countdown; busy while the
// bank may not yet be precharged.
module bank_wr_timer #(
    parameter int TWR = 4
) (
    input  logic clk,
    input  logic rstn,
    input  logic load,
    output logic busy
);

    localparam int CW = $clog2(TWR + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // A fresh WR restarts recovery from the full window.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = CW'(TWR);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign busy = (cnt_q != '0);

endmodule

// File: rtl/sdram_wr_recovery_guard.sv
// Command-issue stage that stalls PRE to any bank
// still inside its write recovery window.
module sdram_wr_recovery_guard
    import sdram_cmd_pkg::*;
#(
    parameter  int BA_WIDTH = 3,
    parameter  int TWR      = TWR_DEFAULT,
    localparam int NBANK    = 2 ** BA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rstn,
    sdram_wr_recovery_guard_if.slave req,
    output cmd_t                  cmd,
    output logic [BA_WIDTH-1:0]   bank,
    output logic [NBANK-1:0]      wr_busy
);

    if (TWR < TWR_MIN || TWR > TWR_MAX) begin : g_bad_twr
        $error("sdram_wr_recovery_guard: TWR must be 1..7");
    end

    logic                blocked;
    logic                accept;
    logic [NBANK-1:0]    wr_load;
    cmd_t                cmd_q;
    cmd_t                cmd_d;
    logic [BA_WIDTH-1:0] bank_q;
    logic [BA_WIDTH-1:0] bank_d;

    assign blocked = req.req_valid
                  && (req.req_cmd == PRE)
                  && wr_busy[req.req_bank];

    assign req.req_ready = !blocked;
    assign accept        = req.req_valid && !blocked;

    always_comb begin
        wr_load = '0;
        if (accept && (req.req_cmd == WR)) begin
            wr_load[req.req_bank] = 1'b1;
        end
    end

    for (genvar g = 0; g < NBANK; g++) begin : g_bank
        bank_wr_timer #(
            .TWR (TWR)
        ) u_timer (
            .clk  (clk),
            .rstn (rstn),
            .load (wr_load[g]),
            .busy (wr_busy[g])
        );
    end

    // Bank address holds across idle cycles; only cmd drops to NOP.
    always_comb begin
        cmd_d  = NOP;
        bank_d = bank_q;
        if (accept) begin
            cmd_d  = req.req_cmd;
            bank_d = req.req_bank;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cmd_q  <= NOP;
            bank_q <= '0;
        end else begin
            cmd_q  <= cmd_d;
            bank_q <= bank_d;
        end
    end

    assign cmd  = cmd_q;
    assign bank = bank_q;

endmodule

// File: tb/tb_sdram_wr_recovery_guard.sv
// Directed and randomized checks of WR-to-PRE recovery
// on three guard instances (TWR = 4, 1, 7).
module tb_sdram_wr_recovery_guard;
    import sdram_cmd_pkg::*;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    sdram_wr_recovery_guard_if #(.BA_WIDTH(3)) ifa ();
    sdram_wr_recovery_guard_if #(.BA_WIDTH(3)) if1 ();
    sdram_wr_recovery_guard_if #(.BA_WIDTH(3)) if7 ();

    cmd_t       cmd_a, cmd_1, cmd_7;
    logic [2:0] bank_a, bank_1, bank_7;
    logic [7:0] busy_a, busy_1, busy_7;

    sdram_wr_recovery_guard #(.BA_WIDTH(3), .TWR(4)) dut_a (
        .clk(clk), .rstn(rstn), .req(ifa),
        .cmd(cmd_a), .bank(bank_a), .wr_busy(busy_a));

    sdram_wr_recovery_guard #(.BA_WIDTH(3), .TWR(1)) dut_1 (
        .clk(clk), .rstn(rstn), .req(if1),
        .cmd(cmd_1), .bank(bank_1), .wr_busy(busy_1));

    sdram_wr_recovery_guard #(.BA_WIDTH(3), .TWR(7)) dut_7 (
        .clk(clk), .rstn(rstn), .req(if7),
        .cmd(cmd_7), .bank(bank_7), .wr_busy(busy_7));

    task automatic set_a(input logic v, input cmd_t c, input logic [2:0] b);
        ifa.req_valid = v;
        ifa.req_cmd   = c;
        ifa.req_bank  = b;
    endtask

    task automatic idle_a(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            set_a(1'b0, NOP, 3'd0);
        end
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if (cmd_a !== NOP || bank_a !== 3'd0 || busy_a !== 8'h00) begin
            errors++;
            $display("FAIL reset_in: cmd=%0d bank=%0d busy=%h want 0/0/00",
                     cmd_a, bank_a, busy_a);
        end
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (cmd_a !== NOP || bank_a !== 3'd0 || busy_a !== 8'h00) begin
            errors++;
            $display("FAIL reset_idle: cmd=%0d bank=%0d busy=%h want 0/0/00",
                     cmd_a, bank_a, busy_a);
        end
        checks++;
        if (ifa.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: got %b want 1", ifa.req_ready);
        end
    endtask

    task automatic test_same_bank();
        @(negedge clk);
        set_a(1'b1, WR, 3'd2); #1;
        checks++;
        if (ifa.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL sb_wr_ready: got %b want 1", ifa.req_ready);
        end
        @(posedge clk); #1;
        checks++;
        if (cmd_a !== WR || bank_a !== 3'd2 || busy_a !== 8'h04) begin
            errors++;
            $display("FAIL sb_wr_bus: cmd=%0d bank=%0d busy=%h want 2/2/04",
                     cmd_a, bank_a, busy_a);
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            set_a(1'b1, PRE, 3'd2); #1;
            checks++;
            if (ifa.req_ready !== 1'b0 || busy_a[2] !== 1'b1) begin
                errors++;
                $display("FAIL sb_block%0d: ready=%b busy2=%b want 0/1",
                         k, ifa.req_ready, busy_a[2]);
            end
            @(posedge clk); #1;
            checks++;
            if (cmd_a !== NOP || bank_a !== 3'd2) begin
                errors++;
                $display("FAIL sb_nop%0d: cmd=%0d bank=%0d want 0/2",
                         k, cmd_a, bank_a);
            end
        end
        @(negedge clk); #1;
        checks++;
        if (ifa.req_ready !== 1'b1 || busy_a !== 8'h00) begin
            errors++;
            $display("FAIL sb_release: ready=%b busy=%h want 1/00",
                     ifa.req_ready, busy_a);
        end
        @(posedge clk); #1;
        checks++;
        if (cmd_a !== PRE || bank_a !== 3'd2) begin
            errors++;
            $display("FAIL sb_pre_bus: cmd=%0d bank=%0d want 1/2",
                     cmd_a, bank_a);
        end
        idle_a(2);
    endtask

    task automatic test_other_bank();
        @(negedge clk);
        set_a(1'b1, WR, 3'd2);
        @(negedge clk);
        set_a(1'b1, PRE, 3'd5); #1;
        checks++;
        if (ifa.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL ob_ready: got %b want 1", ifa.req_ready);
        end
        @(posedge clk); #1;
        checks++;
        if (cmd_a !== PRE || bank_a !== 3'd5 || busy_a !== 8'h04) begin
            errors++;
            $display("FAIL ob_bus: cmd=%0d bank=%0d busy=%h want 1/5/04",
                     cmd_a, bank_a, busy_a);
        end
        idle_a(6);
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        set_a(1'b1, WR, 3'd1);
        @(negedge clk);
        set_a(1'b0, NOP, 3'd0);
        @(negedge clk);
        set_a(1'b1, WR, 3'd1); #1;
        checks++;
        if (ifa.req_ready !== 1'b1 || busy_a !== 8'h02) begin
            errors++;
            $display("FAIL b2b_wr2: ready=%b busy=%h want 1/02",
                     ifa.req_ready, busy_a);
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            set_a(1'b1, PRE, 3'd1); #1;
            checks++;
            if (ifa.req_ready !== 1'b0) begin
                errors++;
                $display("FAIL b2b_block%0d: ready=%b want 0",
                         k, ifa.req_ready);
            end
        end
        @(negedge clk); #1;
        checks++;
        if (ifa.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_release: ready=%b want 1", ifa.req_ready);
        end
        @(posedge clk); #1;
        checks++;
        if (cmd_a !== PRE || bank_a !== 3'd1) begin
            errors++;
            $display("FAIL b2b_pre_bus: cmd=%0d bank=%0d want 1/1",
                     cmd_a, bank_a);
        end
        idle_a(2);
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        set_a(1'b1, WR, 3'd3);
        @(posedge clk); #1;
        set_a(1'b0, NOP, 3'd0);
        checks++;
        if (cmd_a !== WR || busy_a !== 8'h08) begin
            errors++;
            $display("FAIL rm_wr: cmd=%0d busy=%h want 2/08", cmd_a, busy_a);
        end
        #1;
        rstn = 1'b0; #1;
        checks++;
        if (cmd_a !== NOP || bank_a !== 3'd0 || busy_a !== 8'h00) begin
            errors++;
            $display("FAIL rm_async: cmd=%0d bank=%0d busy=%h want 0/0/00",
                     cmd_a, bank_a, busy_a);
        end
        @(negedge clk);
        rstn = 1'b1;
        set_a(1'b1, PRE, 3'd3); #1;
        checks++;
        if (ifa.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL rm_ready: got %b want 1", ifa.req_ready);
        end
        @(posedge clk); #1;
        checks++;
        if (cmd_a !== PRE || bank_a !== 3'd3) begin
            errors++;
            $display("FAIL rm_pre_bus: cmd=%0d bank=%0d want 1/3",
                     cmd_a, bank_a);
        end
        idle_a(1);
    endtask

    task automatic test_twr1();
        @(negedge clk);
        if1.req_valid = 1'b1; if1.req_cmd = WR; if1.req_bank = 3'd4;
        @(posedge clk); #1;
        checks++;
        if (cmd_1 !== WR || busy_1 !== 8'h10) begin
            errors++;
            $display("FAIL t1_wr: cmd=%0d busy=%h want 2/10", cmd_1, busy_1);
        end
        @(negedge clk);
        if1.req_cmd = PRE; #1;
        checks++;
        if (if1.req_ready !== 1'b0) begin
            errors++;
            $display("FAIL t1_block: ready=%b want 0", if1.req_ready);
        end
        @(posedge clk); #1;
        checks++;
        if (cmd_1 !== NOP || busy_1 !== 8'h00) begin
            errors++;
            $display("FAIL t1_gap: cmd=%0d busy=%h want 0/00", cmd_1, busy_1);
        end
        @(negedge clk); #1;
        checks++;
        if (if1.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL t1_release: ready=%b want 1", if1.req_ready);
        end
        @(posedge clk); #1;
        checks++;
        if (cmd_1 !== PRE || bank_1 !== 3'd4) begin
            errors++;
            $display("FAIL t1_pre_bus: cmd=%0d bank=%0d want 1/4",
                     cmd_1, bank_1);
        end
        @(negedge clk);
        if1.req_valid = 1'b0; if1.req_cmd = NOP; if1.req_bank = 3'd0;
        idle_a(3);
    endtask

    task automatic test_random();
        int         twr[2];
        logic       v[2];
        cmd_t       c[2];
        logic [2:0] b[2];
        logic       r[2];
        int         wait_c[2];
        int         lw[2][8];
        cmd_t       ec[2];
        logic [2:0] eb[2];
        logic       exp_r;
        cmd_t       oc;
        logic [2:0] ob;
        int         cyc;
        twr[0] = 1;
        twr[1] = 7;
        eb[0] = 3'd4;
        eb[1] = 3'd0;
        cyc = 0;
        for (int d = 0; d < 2; d++) begin
            v[d] = 1'b0;
            r[d] = 1'b1;
            wait_c[d] = 0;
            for (int k = 0; k < 8; k++) lw[d][k] = -100;
        end
        for (int n = 0; n < 600; n++) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                if (!(v[d] && !r[d])) begin
                    v[d] = ($urandom_range(0, 3) != 0);
                    c[d] = cmd_t'($urandom_range(0, 3));
                    b[d] = 3'($urandom_range(0, 2));
                end
            end
            if1.req_valid = v[0]; if1.req_cmd = c[0]; if1.req_bank = b[0];
            if7.req_valid = v[1]; if7.req_cmd = c[1]; if7.req_bank = b[1];
            #1;
            r[0] = if1.req_ready;
            r[1] = if7.req_ready;
            for (int d = 0; d < 2; d++) begin
                exp_r = !(v[d] && c[d] == PRE
                          && (cyc - lw[d][b[d]]) < twr[d]);
                checks++;
                if (r[d] !== exp_r) begin
                    errors++;
                    $display("FAIL rnd_ready twr=%0d cyc=%0d: got %b want %b",
                             twr[d], cyc, r[d], exp_r);
                end
                if (v[d] && !r[d]) begin
                    wait_c[d]++;
                    checks++;
                    if (wait_c[d] > twr[d]) begin
                        errors++;
                        $display("FAIL rnd_stall twr=%0d: waited %0d max %0d",
                                 twr[d], wait_c[d], twr[d]);
                    end
                end else begin
                    wait_c[d] = 0;
                end
                if (v[d] && r[d]) begin
                    ec[d] = c[d];
                    eb[d] = b[d];
                end else begin
                    ec[d] = NOP;
                end
            end
            @(posedge clk); #1;
            cyc++;
            for (int d = 0; d < 2; d++) begin
                oc = (d == 0) ? cmd_1 : cmd_7;
                ob = (d == 0) ? bank_1 : bank_7;
                checks++;
                if (oc !== ec[d] || ob !== eb[d]) begin
                    errors++;
                    $display("FAIL rnd_bus twr=%0d cyc=%0d: %0d/%0d want %0d/%0d",
                             twr[d], cyc, oc, ob, ec[d], eb[d]);
                end
                if (oc == PRE) begin
                    checks++;
                    if (cyc - lw[d][ob] <= twr[d]) begin
                        errors++;
                        $display("FAIL rnd_twr twr=%0d: PRE %0d cycles after WR",
                                 twr[d], cyc - lw[d][ob]);
                    end
                end
                if (oc == WR) lw[d][ob] = cyc;
            end
        end
        @(negedge clk);
        if1.req_valid = 1'b0;
        if7.req_valid = 1'b0;
    endtask

    initial begin
        set_a(1'b0, NOP, 3'd0);
        if1.req_valid = 1'b0; if1.req_cmd = NOP; if1.req_bank = 3'd0;
        if7.req_valid = 1'b0; if7.req_cmd = NOP; if7.req_bank = 3'd0;
        test_reset();
        test_same_bank();
        test_other_bank();
        test_back_to_back();
        test_reset_mid();
        test_twr1();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
